// File: rtl/bandit_game_ctrl.sv
// Three-reel bandit game sequencer: spins, stops reels on timer or player pulse, scores, keeps credit.
// Optional macro BANDIT_JACKPOT_EN: a 7-7-7 result pays 50 instead of 10.
module bandit_game_ctrl #(
  parameter int unsigned SPIN_CYCLES = 5_000_000,
  parameter int unsigned STOP_GAP    = 2_500_000,
  parameter int unsigned STEP_DIV    = 250_000,
  parameter int unsigned INIT_CREDIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_p,
  input  logic       stop_p,
  output logic [3:0] reel0,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic [7:0] credit,
  output logic       busy,
  output logic       win,
  output logic [5:0] payout
);

  localparam int unsigned PHASE_MAX = (SPIN_CYCLES > STOP_GAP) ? SPIN_CYCLES : STOP_GAP;
  localparam int unsigned PW = $clog2(PHASE_MAX);
  localparam int unsigned SW = $clog2(STEP_DIV);

  typedef enum logic [2:0] {IDLE, SPIN, STOP1, STOP2, RESULT} state_t;

  state_t        state;
  logic [PW-1:0] phase_cnt;
  logic [SW-1:0] step_cnt;
  logic          phase_end;
  logic          step_tick;
  logic          adv0, adv1, adv2;
  logic [5:0]    score;
  logic [8:0]    credit_sum;

  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // A reel that freezes on this edge must not also take the step.
  always_comb begin
    if (state == SPIN)
      phase_end = (phase_cnt == PW'(SPIN_CYCLES - 1)) || stop_p;
    else
      phase_end = (phase_cnt == PW'(STOP_GAP - 1)) || stop_p;
    step_tick = (step_cnt == SW'(STEP_DIV - 1));
    adv0 = step_tick && (state == SPIN) && !phase_end;
    adv1 = step_tick && ((state == SPIN) || ((state == STOP1) && !phase_end));
    adv2 = step_tick && ((state == SPIN) || (state == STOP1) ||
                         ((state == STOP2) && !phase_end));
  end

  always_comb begin
    score = 6'd0;
    if ((reel0 == reel1) && (reel1 == reel2)) begin
`ifdef BANDIT_JACKPOT_EN
      score = (reel0 == 4'd7) ? 6'd50 : 6'd10;
`else
      score = 6'd10;
`endif
    end else if ((reel0 == reel1) || (reel1 == reel2) || (reel0 == reel2)) begin
      score = 6'd2;
    end
    credit_sum = {1'b0, credit} + {3'b000, score};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      step_cnt  <= '0;
      reel0     <= '0;
      reel1     <= '0;
      reel2     <= '0;
      credit    <= 8'(INIT_CREDIT);
      busy      <= 1'b0;
      win       <= 1'b0;
      payout    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_p && (credit != '0)) begin
            credit    <= credit - 8'd1;
            win       <= 1'b0;
            payout    <= '0;
            phase_cnt <= '0;
            step_cnt  <= '0;
            busy      <= 1'b1;
            state     <= SPIN;
          end
        end
        SPIN, STOP1, STOP2: begin
          step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
          if (adv0) reel0 <= next_digit(reel0);
          if (adv1) reel1 <= next_digit(reel1);
          if (adv2) reel2 <= next_digit(reel2);
          if (phase_end) begin
            phase_cnt <= '0;
            case (state)
              SPIN:    state <= STOP1;
              STOP1:   state <= STOP2;
              default: state <= RESULT;
            endcase
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        RESULT: begin
          credit <= credit_sum[8] ? 8'hFF : credit_sum[7:0];
          win    <= (score != '0);
          payout <= score;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bandit_game_ctrl.sv
// Randomized self-checking bench for bandit_game_ctrl; expected results come from freeze-time arithmetic.
module tb_bandit_game_ctrl;

  localparam int STEP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_p [3];
  logic       stop_p  [3];
  logic [3:0] r0 [3];
  logic [3:0] r1 [3];
  logic [3:0] r2 [3];
  logic [7:0] cr [3];
  logic       bz [3];
  logic       wn [3];
  logic [5:0] po [3];

  int passed = 0;
  int total  = 0;

  int m_reel   [3][3];
  int m_credit [3];
  int m_win    [3];
  int m_payout [3];
  int stops [$];

  always #5 clk = ~clk;

  bandit_game_ctrl #(.SPIN_CYCLES(20), .STOP_GAP(8), .STEP_DIV(2), .INIT_CREDIT(3)) u_dut0 (
    .clk(clk), .rst(rst), .start_p(start_p[0]), .stop_p(stop_p[0]),
    .reel0(r0[0]), .reel1(r1[0]), .reel2(r2[0]), .credit(cr[0]),
    .busy(bz[0]), .win(wn[0]), .payout(po[0]));

  bandit_game_ctrl #(.SPIN_CYCLES(16), .STOP_GAP(20), .STEP_DIV(2), .INIT_CREDIT(3)) u_dut1 (
    .clk(clk), .rst(rst), .start_p(start_p[1]), .stop_p(stop_p[1]),
    .reel0(r0[1]), .reel1(r1[1]), .reel2(r2[1]), .credit(cr[1]),
    .busy(bz[1]), .win(wn[1]), .payout(po[1]));

  bandit_game_ctrl #(.SPIN_CYCLES(16), .STOP_GAP(20), .STEP_DIV(2), .INIT_CREDIT(250)) u_dut2 (
    .clk(clk), .rst(rst), .start_p(start_p[2]), .stop_p(stop_p[2]),
    .reel0(r0[2]), .reel1(r1[2]), .reel2(r2[2]), .credit(cr[2]),
    .busy(bz[2]), .win(wn[2]), .payout(po[2]));

  function automatic int spin_of(input int i);
    return (i == 0) ? 20 : 16;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 8 : 20;
  endfunction

  function automatic int init_of(input int i);
    return (i == 2) ? 250 : 3;
  endfunction

  function automatic int score_of(input int a, input int b, input int c);
    if (a == b && b == c) begin
`ifdef BANDIT_JACKPOT_EN
      if (a == 7) return 50;
`endif
      return 10;
    end
    if (a == b || b == c || a == c) return 2;
    return 0;
  endfunction

  function automatic bit is_stop(input int t);
    foreach (stops[k]) if (stops[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) m_reel[i][k] = 0;
      m_credit[i] = init_of(i);
      m_win[i] = 0;
      m_payout[i] = 0;
    end
  endtask

  // One game on instance i using the pulse cycles in 'stops' (relative to SPIN entry).
  task automatic play(input int i, input bit junk);
    int f0, f1, f2, busy_n, pay;
    if (m_credit[i] == 0) begin
      @(negedge clk); start_p[i] = 1'b1;
      @(negedge clk); start_p[i] = 1'b0;
      total++;
      if (bz[i] !== 1'b0 || cr[i] !== 8'd0)
        $display("FAIL zero_credit_start inst%0d: busy=%0b credit=%0d, required busy=0 credit=0", i, bz[i], cr[i]);
      else passed++;
      return;
    end
    f0 = spin_of(i) - 1;
    foreach (stops[k]) if (stops[k] < f0) begin f0 = stops[k]; break; end
    f1 = f0 + gap_of(i);
    foreach (stops[k]) if (stops[k] > f0 && stops[k] < f1) begin f1 = stops[k]; break; end
    f2 = f1 + gap_of(i);
    foreach (stops[k]) if (stops[k] > f1 && stops[k] < f2) begin f2 = stops[k]; break; end
    m_credit[i] = m_credit[i] - 1;

    @(negedge clk); start_p[i] = 1'b1;
    @(negedge clk); start_p[i] = 1'b0;
    total++;
    if (bz[i] !== 1'b1 || int'(cr[i]) !== m_credit[i] || wn[i] !== 1'b0 || po[i] !== 6'd0)
      $display("FAIL game_entry inst%0d: busy=%0b credit=%0d win=%0b payout=%0d, required 1/%0d/0/0",
               i, bz[i], cr[i], wn[i], po[i], m_credit[i]);
    else passed++;

    busy_n = 0;
    for (int t = 0; t <= f2 + 1; t++) begin
      if (bz[i] === 1'b1) busy_n++;
      stop_p[i]  = is_stop(t);
      start_p[i] = junk && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    stop_p[i]  = 1'b0;
    start_p[i] = 1'b0;

    m_reel[i][0] = (m_reel[i][0] + f0 / STEP) % 10;
    m_reel[i][1] = (m_reel[i][1] + f1 / STEP) % 10;
    m_reel[i][2] = (m_reel[i][2] + f2 / STEP) % 10;
    pay = score_of(m_reel[i][0], m_reel[i][1], m_reel[i][2]);
    m_credit[i] = (m_credit[i] + pay > 255) ? 255 : m_credit[i] + pay;
    m_win[i] = (pay != 0);
    m_payout[i] = pay;

    total++;
    if (busy_n !== f2 + 2 || bz[i] !== 1'b0)
      $display("FAIL busy_length inst%0d: busy cycles=%0d busy_now=%0b, required %0d and 0", i, busy_n, bz[i], f2 + 2);
    else passed++;
    total++;
    if (int'(r0[i]) !== m_reel[i][0] || int'(r1[i]) !== m_reel[i][1] || int'(r2[i]) !== m_reel[i][2])
      $display("FAIL reels inst%0d: %0d/%0d/%0d, required %0d/%0d/%0d", i, r0[i], r1[i], r2[i],
               m_reel[i][0], m_reel[i][1], m_reel[i][2]);
    else passed++;
    total++;
    if (int'(cr[i]) !== m_credit[i] || int'(wn[i]) !== m_win[i] || int'(po[i]) !== m_payout[i])
      $display("FAIL score inst%0d: credit=%0d win=%0b payout=%0d, required %0d/%0d/%0d", i, cr[i], wn[i], po[i],
               m_credit[i], m_win[i], m_payout[i]);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (r0[i] !== 4'd0 || r1[i] !== 4'd0 || r2[i] !== 4'd0 || int'(cr[i]) !== init_of(i) ||
          bz[i] !== 1'b0 || wn[i] !== 1'b0 || po[i] !== 6'd0)
        $display("FAIL reset inst%0d: reels %0d/%0d/%0d credit=%0d busy=%0b win=%0b payout=%0d, required 0/0/0 %0d 0 0 0",
                 i, r0[i], r1[i], r2[i], cr[i], bz[i], wn[i], po[i], init_of(i));
      else passed++;
    end
  endtask

  task automatic test_plain();
    test_reset();
    stops.delete();
    play(0, 1'b0);
    total++;
    if (r0[0] !== 4'd9 || r1[0] !== 4'd3 || r2[0] !== 4'd7 || cr[0] !== 8'd2 || wn[0] !== 1'b0)
      $display("FAIL plain_const: reels %0d/%0d/%0d credit=%0d win=%0b, required 9/3/7 2 0", r0[0], r1[0], r2[0], cr[0], wn[0]);
    else passed++;
  endtask

  task automatic test_jackpot();
    test_reset();
    stops.delete();
    play(1, 1'b0);
    play(2, 1'b0);
    total++;
`ifdef BANDIT_JACKPOT_EN
    if (r0[1] !== 4'd7 || r1[1] !== 4'd7 || r2[1] !== 4'd7 || cr[1] !== 8'd52 || po[1] !== 6'd50)
      $display("FAIL jackpot_const: reels %0d/%0d/%0d credit=%0d payout=%0d, required 7/7/7 52 50", r0[1], r1[1], r2[1], cr[1], po[1]);
`else
    if (r0[1] !== 4'd7 || r1[1] !== 4'd7 || r2[1] !== 4'd7 || cr[1] !== 8'd12 || po[1] !== 6'd10)
      $display("FAIL jackpot_const: reels %0d/%0d/%0d credit=%0d payout=%0d, required 7/7/7 12 10", r0[1], r1[1], r2[1], cr[1], po[1]);
`endif
    else passed++;
    total++;
    if (cr[2] !== 8'd255)
      $display("FAIL saturate: credit=%0d, required 255", cr[2]);
    else passed++;
  endtask

  task automatic test_triple();
    test_reset();
    stops = '{0, 1};
    play(1, 1'b0);
    total++;
    if (r0[1] !== 4'd0 || r1[1] !== 4'd0 || r2[1] !== 4'd0 || cr[1] !== 8'd12 || wn[1] !== 1'b1)
      $display("FAIL triple_const: reels %0d/%0d/%0d credit=%0d win=%0b, required 0/0/0 12 1", r0[1], r1[1], r2[1], cr[1], wn[1]);
    else passed++;
  endtask

  task automatic test_pair();
    test_reset();
    stops = '{1, 2, 3};
    play(0, 1'b0);
    total++;
    if (po[0] !== 6'd2 || cr[0] !== 8'd4)
      $display("FAIL pair_const: payout=%0d credit=%0d, required 2 4", po[0], cr[0]);
    else passed++;
  endtask

  task automatic test_player_stop();
    test_reset();
    stops = '{5, 13};
    play(0, 1'b1);
    total++;
    if (r0[0] !== 4'd2 || r1[0] !== 4'd6 || r2[0] !== 4'd0)
      $display("FAIL player_stop_const: reels %0d/%0d/%0d, required 2/6/0", r0[0], r1[0], r2[0]);
    else passed++;
  endtask

  task automatic test_idle_ignore();
    @(negedge clk); stop_p[0] = 1'b1;
    @(negedge clk); stop_p[0] = 1'b0;
    total++;
    if (bz[0] !== 1'b0 || int'(r0[0]) !== m_reel[0][0] || int'(cr[0]) !== m_credit[0])
      $display("FAIL idle_stop: busy=%0b reel0=%0d credit=%0d, required 0 %0d %0d", bz[0], r0[0], cr[0], m_reel[0][0], m_credit[0]);
    else passed++;
  endtask

  task automatic test_zero_credit();
    test_reset();
    stops.delete();
    for (int g = 0; g < 10 && m_credit[0] != 0; g++) play(0, 1'b0);
    total++;
    if (m_credit[0] != 0 || cr[0] !== 8'd0)
      $display("FAIL drain_credit: credit=%0d model=%0d, required 0", cr[0], m_credit[0]);
    else passed++;
    play(0, 1'b0);
  endtask

  task automatic test_reset_mid_game();
    test_reset();
    @(negedge clk); start_p[0] = 1'b1;
    @(negedge clk); start_p[0] = 1'b0;
    repeat (22) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    total++;
    if (bz[0] !== 1'b0 || r0[0] !== 4'd0 || r1[0] !== 4'd0 || r2[0] !== 4'd0 || cr[0] !== 8'd3 || wn[0] !== 1'b0)
      $display("FAIL reset_mid_game: busy=%0b reels %0d/%0d/%0d credit=%0d win=%0b, required 0 0/0/0 3 0",
               bz[0], r0[0], r1[0], r2[0], cr[0], wn[0]);
    else passed++;
  endtask

  task automatic test_random();
    int c;
    test_reset();
    for (int g = 0; g < 40; g++) begin
      stops.delete();
      c = 0;
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
        c += $urandom_range(0, 12);
        stops.push_back(c);
        c++;
      end
      play(int'($urandom_range(0, 2)), 1'b1);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_p[i] = 1'b0;
      stop_p[i]  = 1'b0;
    end
    test_reset();
    test_plain();
    test_idle_ignore();
    test_jackpot();
    test_triple();
    test_pair();
    test_player_stop();
    test_zero_credit();
    test_reset_mid_game();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
